// File: rtl/parallel_serializer.sv
// Parallel-to-serial converter: captures a SIZE-element word and emits it one
// element per accepted beat, highest index first, with valid/ready on both sides.
module parallel_serializer #(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE*DATA_WIDTH-1:0]   data_in,
    input  logic                         load_valid,
    output logic                         load_ready,
    output logic [DATA_WIDTH-1:0]        shift_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy
);

    localparam int              CW         = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0]   LAST_COUNT = CW'(SIZE - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]                 state_q;
    logic [0:0]                 state_d;
    logic [CW-1:0]              count_q;
    logic [CW-1:0]              count_d;
    logic [SIZE*DATA_WIDTH-1:0] word_q;
    logic [SIZE*DATA_WIDTH-1:0] word_d;

    logic [DATA_WIDTH-1:0]      elem [SIZE];
    logic [DATA_WIDTH-1:0]      elem_sel;
    logic [CW-1:0]              sel;
    logic                       load_fire;
    logic                       beat_fire;

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_elem
            assign elem[gi] = word_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The beat counter runs upward while elements leave from the top index down.
    assign sel = LAST_COUNT - count_q;

    always_comb begin
        elem_sel = '0;
        for (int k = 0; k < SIZE; k++) begin
            if (sel == CW'(k)) begin
                elem_sel = elem[k];
            end
        end
    end

    assign out_valid = (state_q == SHIFT);
    assign busy      = out_valid;
    assign out_last  = out_valid && (count_q == LAST_COUNT);
    assign shift_out = out_valid ? elem_sel : '0;

    // Accepting during the final beat lets consecutive words stream without a gap.
    assign load_ready = !out_valid || (out_last && out_ready);
    assign load_fire  = load_valid && load_ready;
    assign beat_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        if (load_fire) begin
            word_d  = data_in;
            count_d = '0;
            state_d = SHIFT;
        end else if (beat_fire) begin
            if (out_last) begin
                count_d = '0;
                state_d = IDLE;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_parallel_serializer.sv
// Scoreboard bench for parallel_serializer: a SIZE=3 and a SIZE=1 instance,
// each tracked by a small handshake model and a queue of expected beats.
module tb_parallel_serializer;

    localparam int DW = 16;

    logic            clock;
    logic            reset;

    logic [3*DW-1:0] data_in3;
    logic            load_valid3, load_ready3, out_ready3, out_valid3, out_last3, busy3;
    logic [DW-1:0]   shift_out3;

    logic [DW-1:0]   data_in1;
    logic            load_valid1, load_ready1, out_ready1, out_valid1, out_last1, busy1;
    logic [DW-1:0]   shift_out1;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry: {last flag, element}
    logic [DW:0] q3 [$];
    logic [DW:0] q1 [$];
    int          rem3 = 0;
    int          rem1 = 0;

    parallel_serializer #(.SIZE(3), .DATA_WIDTH(DW)) dut3 (
        .clock(clock), .reset(reset), .data_in(data_in3),
        .load_valid(load_valid3), .load_ready(load_ready3),
        .shift_out(shift_out3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_last(out_last3), .busy(busy3)
    );

    parallel_serializer #(.SIZE(1), .DATA_WIDTH(DW)) dut1 (
        .clock(clock), .reset(reset), .data_in(data_in1),
        .load_valid(load_valid1), .load_ready(load_ready1),
        .shift_out(shift_out1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_last(out_last1), .busy(busy1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // SIZE=3 monitor and model
    always @(negedge clock) begin
        logic       exp_v;
        logic       exp_rdy;
        logic [DW:0] front;
        if (reset) begin
            check_val("rst3_valid", out_valid3, 0);
            check_val("rst3_data", shift_out3, 0);
            check_val("rst3_last", out_last3, 0);
            check_val("rst3_busy", busy3, 0);
            check_val("rst3_ready", load_ready3, 1);
            q3.delete();
            rem3 = 0;
        end else begin
            exp_v   = (rem3 != 0);
            exp_rdy = (rem3 == 0) || (rem3 == 1 && out_ready3);
            check_val("valid3", out_valid3, exp_v);
            check_val("busy3", busy3, exp_v);
            check_val("ready3", load_ready3, exp_rdy);
            if (exp_v && q3.size() > 0) begin
                front = q3[0];
                check_val("data3", shift_out3, front[DW-1:0]);
                check_val("last3", out_last3, front[DW]);
                if (out_ready3) begin
                    void'(q3.pop_front());
                    rem3--;
                end
            end else begin
                check_val("idle_data3", shift_out3, 0);
                check_val("idle_last3", out_last3, 0);
            end
            if (load_valid3 && exp_rdy) begin
                for (int k = 2; k >= 0; k--) begin
                    q3.push_back({(k == 0), data_in3[k*DW +: DW]});
                end
                rem3 = 3;
            end
        end
    end

    // SIZE=1 monitor and model
    always @(negedge clock) begin
        logic       exp_v;
        logic       exp_rdy;
        logic [DW:0] front;
        if (reset) begin
            check_val("rst1_valid", out_valid1, 0);
            check_val("rst1_ready", load_ready1, 1);
            q1.delete();
            rem1 = 0;
        end else begin
            exp_v   = (rem1 != 0);
            exp_rdy = (rem1 == 0) || (rem1 == 1 && out_ready1);
            check_val("valid1", out_valid1, exp_v);
            check_val("busy1", busy1, exp_v);
            check_val("ready1", load_ready1, exp_rdy);
            if (exp_v && q1.size() > 0) begin
                front = q1[0];
                check_val("data1", shift_out1, front[DW-1:0]);
                check_val("last1", out_last1, front[DW]);
                if (out_ready1) begin
                    void'(q1.pop_front());
                    rem1--;
                end
            end else begin
                check_val("idle_data1", shift_out1, 0);
                check_val("idle_last1", out_last1, 0);
            end
            if (load_valid1 && exp_rdy) begin
                q1.push_back({1'b1, data_in1});
                rem1 = 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && !(q3.size() == 0 && rem3 == 0 && q1.size() == 0 && rem1 == 0); i++) begin
            tick(1);
        end
        check_val("drain_timeout", q3.size() + q1.size(), 0);
        tick(2);
    endtask

    task automatic load3(input logic [3*DW-1:0] w);
        data_in3    = w;
        load_valid3 = 1'b1;
        tick(1);
        load_valid3 = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        data_in3    = '0;
        load_valid3 = 1'b0;
        out_ready3  = 1'b1;
        data_in1    = '0;
        load_valid1 = 1'b0;
        out_ready1  = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);

        // basic order
        load3({16'h0003, 16'h0002, 16'h0001});
        drain();

        // backpressure
        out_ready3 = 1'b0;
        load3({16'h0003, 16'h0002, 16'h0001});
        tick(4);
        out_ready3 = 1'b1;
        drain();

        // back-to-back words with load_valid held
        data_in3    = {16'h000C, 16'h000B, 16'h000A};
        load_valid3 = 1'b1;
        tick(1);
        data_in3    = {16'h00F0, 16'h00E0, 16'h00D0};
        tick(3);
        load_valid3 = 1'b0;
        drain();

        // load attempt during the second beat must be ignored
        load3({16'h0033, 16'h0022, 16'h0011});
        tick(1);
        data_in3    = {16'hBEEF, 16'hDEAD, 16'hCAFE};
        load_valid3 = 1'b1;
        tick(1);
        load_valid3 = 1'b0;
        drain();

        // reset after the first beat
        load3({16'h0A03, 16'h0A02, 16'h0A01});
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        load3({16'h0B03, 16'h0B02, 16'h0B01});
        drain();

        // SIZE=1: one word per cycle
        data_in1    = 16'h1111;
        load_valid1 = 1'b1;
        tick(1);
        data_in1    = 16'h2222;
        tick(1);
        load_valid1 = 1'b0;
        drain();

        // SIZE=1 under backpressure
        out_ready1  = 1'b0;
        data_in1    = 16'h3333;
        load_valid1 = 1'b1;
        tick(1);
        data_in1    = 16'h4444;
        tick(2);
        load_valid1 = 1'b0;
        out_ready1  = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
